// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

    // Transaction sequencer: every access walks IDLE -> ACCESS -> RESP -> IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Which requester owns the transaction currently in flight.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Width of the memory-latency down-counter; one spare bit keeps MEM_LAT=1 legal.
    function automatic int lat_w(input int mem_lat);
        return $clog2(mem_lat) + 1;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner selection: D has priority unless I has been starved
// for STARVE_MAX consecutive D grants.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_valid,
    output owner_e           grant_owner
);

    logic w_starved;

    assign w_starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // Pick a winner from whichever requests are pending.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_valid = i_req | d_req;
        grant_owner = OWN_I;
        if (d_req && !(i_req && w_starved)) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the instruction-fetch (I) and load/store (D) ports onto one
// single-port memory. One transaction at a time; all outputs are registered.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_adr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    // memory port
    output logic [ADDR_W-1:0] m_adr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_read,
    output logic              m_write,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int          LW       = lat_w(MEM_LAT);
    localparam int          CNT_W    = $clog2(STARVE_MAX + 1);
    localparam logic [LW-1:0]    LAT_INIT = LW'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);

    state_e             r_state;
    owner_e             r_owner;
    logic               r_we;
    logic [ADDR_W-1:0]  r_adr;
    logic [DATA_W-1:0]  r_wdata;
    logic [LW-1:0]      r_lat_cnt;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic               r_m_read;
    logic               r_m_write;
    logic               r_i_ack;
    logic               r_d_ack;
    logic [DATA_W-1:0]  r_i_rdata;
    logic [DATA_W-1:0]  r_d_rdata;

    logic               w_grant_valid;
    owner_e             w_grant_owner;
    logic [CNT_W-1:0]   w_starve_inc;

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_grant (
        .i_req       (i_req),
        .d_req       (d_req),
        .starve_cnt  (r_starve_cnt),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    // Saturating increment used when D wins while I is still waiting.
    assign w_starve_inc = (r_starve_cnt == CNT_MAX) ? r_starve_cnt
                                                    : r_starve_cnt + CNT_W'(1);

    // Transaction FSM with registered memory strobes, acks and read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_D;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_wdata      <= '0;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_m_read     <= 1'b0;
            r_m_write    <= 1'b0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            unique case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner   <= w_grant_owner;
                        r_lat_cnt <= LAT_INIT;
                        r_state   <= ACCESS;
                        if (w_grant_owner == OWN_D) begin
                            r_adr        <= d_adr;
                            r_we         <= d_we;
                            r_wdata      <= d_wdata;
                            r_m_read     <= ~d_we;
                            r_m_write    <= d_we;
                            r_starve_cnt <= i_req ? w_starve_inc : '0;
                        end else begin
                            r_adr        <= i_adr;
                            r_we         <= 1'b0;
                            r_wdata      <= '0;
                            r_m_read     <= 1'b1;
                            r_m_write    <= 1'b0;
                            r_starve_cnt <= '0;
                        end
                    end
                end

                ACCESS: begin
                    if (r_lat_cnt == '0) begin
                        r_m_read  <= 1'b0;
                        r_m_write <= 1'b0;
                        r_state   <= RESP;
                        if (r_owner == OWN_I) begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= m_rdata;
                        end else begin
                            r_d_ack <= 1'b1;
                            // A store leaves the last load result in place.
                            if (!r_we) begin
                                r_d_rdata <= m_rdata;
                            end
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LW'(1);
                    end
                end

                RESP: begin
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_m_read  <= 1'b0;
                    r_m_write <= 1'b0;
                    r_i_ack   <= 1'b0;
                    r_d_ack   <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign i_ack   = r_i_ack;
    assign i_rdata = r_i_rdata;
    assign d_ack   = r_d_ack;
    assign d_rdata = r_d_rdata;
    assign m_adr   = r_adr;
    assign m_wdata = r_wdata;
    assign m_read  = r_m_read;
    assign m_write = r_m_write;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 (dut) and
// one with MEM_LAT=3 (dut3), each backed by a small word-addressed memory.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- MEM_LAT = 1 instance ----------------
    logic        i_req, i_ack, d_req, d_we, d_ack, m_read, m_write;
    logic [31:0] i_adr, i_rdata, d_adr, d_wdata, d_rdata, m_adr, m_wdata, m_rdata;
    logic [31:0] mem_a [0:63];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_adr(m_adr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
        .m_rdata(m_rdata)
    );

    assign m_rdata = mem_a[m_adr[7:2]];
    always_ff @(posedge clk) if (m_write) mem_a[m_adr[7:2]] <= m_wdata;

    // ---------------- MEM_LAT = 3 instance ----------------
    logic        i_req3, i_ack3, d_req3, d_we3, d_ack3, m_read3, m_write3;
    logic [31:0] i_adr3, i_rdata3, d_adr3, d_wdata3, d_rdata3, m_adr3, m_wdata3, m_rdata3;
    logic [31:0] mem_b [0:63];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req3), .i_adr(i_adr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_adr(d_adr3), .d_wdata(d_wdata3),
        .d_ack(d_ack3), .d_rdata(d_rdata3),
        .m_adr(m_adr3), .m_wdata(m_wdata3), .m_read(m_read3), .m_write(m_write3),
        .m_rdata(m_rdata3)
    );

    assign m_rdata3 = mem_b[m_adr3[7:2]];
    always_ff @(posedge clk) if (m_write3) mem_b[m_adr3[7:2]] <= m_wdata3;

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no ack within cycle budget", name);
    endtask

    // Wait for any ack on dut; k counts falling edges from the call.
    task automatic wait_ack_a(input string name, output int k);
        bit got;
        k   = 0;
        got = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (i_ack || d_ack) got = 1;
        end
        if (!got) timeout(name);
    endtask

    // One dut3 transaction on the D port, counting strobe cycles until ack.
    task automatic run_b(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                         input bit hold, output int k, output int rd_cnt, output int wr_cnt);
        bit got;
        k = 0; rd_cnt = 0; wr_cnt = 0; got = 0;
        if (!hold) begin
            @(negedge clk);
            d_req3 = 1'b1; d_we3 = we; d_adr3 = adr; d_wdata3 = wdata;
        end
        while (!got && k < 30) begin
            @(negedge clk);
            k++;
            if (m_read3)  rd_cnt++;
            if (m_write3) wr_cnt++;
            if (d_ack3) got = 1;
        end
        if (!got) timeout("dut3 ack");
    endtask

    typedef struct {
        logic        port_d;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;  // i_rdata for fetches, d_rdata for D (store: unchanged value)
    } vec_t;

    vec_t vecs [10];

    initial begin : main
        int k, rd_cnt, wr_cnt;
        logic [1:0] exp_own [10];

        rst = 1'b1;
        i_req = 0; i_adr = '0; d_req = 0; d_we = 0; d_adr = '0; d_wdata = '0;
        i_req3 = 0; i_adr3 = '0; d_req3 = 0; d_we3 = 0; d_adr3 = '0; d_wdata3 = '0;

        // ---- vector table (MEM_LAT=1): {port_d, we, adr, wdata, expected rdata} ----
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0004, 32'h2002_000A, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0008, 32'h8C01_0010, 32'h0000_0000};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h2002_000A};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h8C01_0010};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h2002_000A};

        // ---- reset state ----
        #12;
        check("reset ctl", 32'({i_ack, d_ack, m_read, m_write}), 32'h0);
        check("reset m_adr", m_adr, 32'h0);
        check("reset m_wdata", m_wdata, 32'h0);
        check("reset i_rdata", i_rdata, 32'h0);
        check("reset d_rdata", d_rdata, 32'h0);
        check("reset dut3 ctl", 32'({i_ack3, d_ack3, m_read3, m_write3}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ---- reset mid-ACCESS ----
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h0000_0040;
        @(negedge clk);
        check("pre-rst m_read", 32'(m_read), 32'h1);
        check("pre-rst m_adr", m_adr, 32'h0000_0040);
        #1 rst = 1'b1;
        #1;
        check("async rst ctl", 32'({i_ack, d_ack, m_read, m_write}), 32'h0);
        check("async rst m_adr", m_adr, 32'h0);
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no d_ack after rst", 32'({i_ack, d_ack}), 32'h0);
        end
        check("idle after rst", 32'(dut.r_state), 32'(IDLE));

        // ---- table-driven single transactions on dut ----
        for (int v = 0; v < 10; v++) begin
            rd_cnt = 0; wr_cnt = 0; k = 0;
            @(negedge clk);
            if (vecs[v].port_d) begin
                d_req = 1'b1; d_we = vecs[v].we; d_adr = vecs[v].adr; d_wdata = vecs[v].wdata;
            end else begin
                i_req = 1'b1; i_adr = vecs[v].adr;
            end
            begin : txn
                bit got;
                got = 0;
                while (!got && k < 20) begin
                    @(negedge clk);
                    k++;
                    if (m_read || m_write) begin
                        rd_cnt += int'(m_read);
                        wr_cnt += int'(m_write);
                        check($sformatf("v%0d m_adr", v), m_adr, vecs[v].adr);
                        if (m_write) check($sformatf("v%0d m_wdata", v), m_wdata, vecs[v].wdata);
                    end
                    if (i_ack || d_ack) got = 1;
                end
                if (!got) timeout($sformatf("v%0d ack", v));
            end
            i_req = 1'b0; d_req = 1'b0;
            check($sformatf("v%0d ack who", v), 32'({i_ack, d_ack}),
                  vecs[v].port_d ? 32'h1 : 32'h2);
            check($sformatf("v%0d latency", v), 32'(k), 32'd2);
            check($sformatf("v%0d rdata", v), vecs[v].port_d ? d_rdata : i_rdata,
                  vecs[v].exp_rdata);
            check($sformatf("v%0d reads", v), 32'(rd_cnt), vecs[v].we ? 32'd0 : 32'd1);
            check($sformatf("v%0d writes", v), 32'(wr_cnt), vecs[v].we ? 32'd1 : 32'd0);
            @(negedge clk);
            check($sformatf("v%0d ack pulse", v), 32'({i_ack, d_ack}), 32'h0);
        end

        // ---- i_adr changes during ACCESS ----
        @(negedge clk);
        i_req = 1'b1; i_adr = 32'h0000_0004;
        @(negedge clk);
        i_adr = 32'h0000_0008;
        #1 check("adr hold m_adr", m_adr, 32'h0000_0004);
        wait_ack_a("adr hold ack", k);
        i_req = 1'b0;
        check("adr hold latency", 32'(k), 32'd1);
        check("adr hold rdata", i_rdata, 32'h2002_000A);
        @(negedge clk);

        // ---- requester drops req mid-transaction ----
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h0000_0020;
        @(negedge clk);
        d_req = 1'b0;
        wait_ack_a("drop req ack", k);
        check("drop req who", 32'({i_ack, d_ack}), 32'h1);
        check("drop req rdata", d_rdata, 32'h1234_5678);
        @(negedge clk);

        // ---- contention with starvation guard ----
        exp_own = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        @(negedge clk);
        i_req = 1'b1; i_adr = 32'h0000_0004;
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h0000_0010;
        for (int g = 0; g < 10; g++) begin
            wait_ack_a($sformatf("contend g%0d", g), k);
            check($sformatf("contend g%0d who", g), 32'({i_ack, d_ack}), 32'(exp_own[g]));
            check($sformatf("contend g%0d spacing", g), 32'(k), (g == 0) ? 32'd2 : 32'd3);
            if (exp_own[g] == 2'b10) check($sformatf("contend g%0d i_rdata", g), i_rdata, 32'h2002_000A);
            else                     check($sformatf("contend g%0d d_rdata", g), d_rdata, 32'hDEAD_BEEF);
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("contend drain", 32'({i_ack, d_ack}), 32'h0);

        // ---- MEM_LAT = 3 ----
        run_b(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, k, rd_cnt, wr_cnt);
        d_req3 = 1'b0;
        check("lat3 store ack cycle", 32'(k), 32'd4);
        check("lat3 store writes", 32'(wr_cnt), 32'd3);
        check("lat3 store d_rdata", d_rdata3, 32'h0);
        @(negedge clk);
        run_b(1'b0, 32'h0000_0040, 32'h0, 1'b0, k, rd_cnt, wr_cnt);
        check("lat3 load ack cycle", 32'(k), 32'd4);
        check("lat3 load reads", 32'(rd_cnt), 32'd3);
        check("lat3 load d_rdata", d_rdata3, 32'hCAFE_F00D);
        // Request still held: the next access follows MEM_LAT+2 cycles later.
        run_b(1'b0, 32'h0000_0040, 32'h0, 1'b1, k, rd_cnt, wr_cnt);
        d_req3 = 1'b0;
        check("lat3 back-to-back spacing", 32'(k), 32'd5);
        check("lat3 back-to-back reads", 32'(rd_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
